avmm_lfsr_gen: RTL and testbench
================================

Name: avmm_lfsr_gen

Overview:
Avalon-MM slave LFSR generator that holds its own seed. It contains a programmable seed, a feedback polynomial, a running LFSR state, an advance counter and a sticky status flag. The HPS/Nios host writes the seed and polynomial over the lightweight bridge, then runs or single-steps the LFSR. Fabric logic consumes the current state through out_port, with a one-cycle strobe on each advance.

Parameters:
WIDTH, 32, LFSR width in bits; legal range 2..32.
RESET_SEED, 32'h3F60_FF91, reset value of SEED; only bits [WIDTH-1:0] are used.
RESET_POLY, 32'h8020_0003, reset value of POLY (Galois feedback mask); only bits [WIDTH-1:0] are used.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  word address
chipselect  in  1  slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, fixed read latency 1
out_port  out  WIDTH  current LFSR state
adv_strobe  out  1  high for one cycle after each state advance
irq  out  1  level interrupt

Behaviour:
- Register map (word addresses):
  - 0 SEED RW.
  - 1 POLY RW.
  - 2 CTRL RW: bit0 RUN, bit1 LOAD (write-only pulse, reads 0), bit2 STEP (write-only pulse, reads 0), bit3 IRQ_EN.
  - 3 STATE RO.
  - 4 COUNT RO, 32-bit.
  - 5 STATUS: bit0 ZERO, sticky, write-1-to-clear.
  - 6, 7: read 0, writes ignored.
- Write strobe: wr = chipselect & ~write_n. Read strobe: rd = chipselect & ~read_n.
- Width rules:
  - Writes to SEED and POLY take writedata[WIDTH-1:0].
  - Reads zero-extend to 32 bits.
  - Writes to RO registers are ignored.
- Reset values:
  - SEED = RESET_SEED, POLY = RESET_POLY.
  - STATE = RESET_SEED.
  - CTRL = 0, COUNT = 0, STATUS = 0.
  - readdata = 0, adv_strobe = 0, irq = 0.
  - out_port therefore equals RESET_SEED[WIDTH-1:0] out of reset.
- Advance function (Galois, right shift): next = (state >> 1) ^ (state[0] ? POLY : 0).
- Per-cycle priority for STATE:
  1. CTRL write with LOAD=1: STATE <= SEED (value held before this edge), COUNT <= 0, no advance.
  2. Else if RUN=1 (CTRL value before this edge): advance, COUNT <= COUNT+1.
  3. Else if CTRL write with STEP=1: exactly one advance, COUNT+1.
  4. Else hold.
- STEP together with RUN=1 in the same write: RUN governs; the step is absorbed, not counted twice.
- Writing RUN=1 starts advancing on the edge after the write. Writing RUN=0 stops after the write edge, so the write cycle itself still advances if RUN was 1.
- adv_strobe: registered, high for the cycle following any edge on which STATE advanced. Not asserted on LOAD.
- COUNT wraps from 0xFFFF_FFFF to 0.
- ZERO: set on any edge where the new STATE is 0, from LOAD or advance. A zero state is stuck; advancing 0 yields 0.
- ZERO set vs. W1C clear in the same cycle: set wins.
- irq = STATUS.ZERO & CTRL.IRQ_EN, registered.
- Reads: readdata is registered one cycle after rd, from the address sampled with rd. When rd=0, readdata is driven to 0.
- Reading STATE in the same cycle as an advance returns the pre-advance value.
- Reset asserted mid-run: all state returns to reset values immediately (asynchronous). RUN is cleared, so the LFSR is idle after release.

Optional Feature:
LFSR_AUTO_RESEED_EN.
- Defined: whenever the new STATE would be 0 (LOAD of a zero SEED, or an advance producing 0), STATE takes RESET_SEED[WIDTH-1:0] instead. ZERO is still set, recording the event. COUNT behaves as without substitution: cleared on LOAD, incremented on advance.
- Undefined: STATE becomes 0 and stays 0 until the next LOAD.

Test Plan:
- Reset, WIDTH=32: read addr0 -> 0x3F60FF91; addr1 -> 0x80200003; addr3 -> 0x3F60FF91; out_port = 0x3F60FF91; irq = 0.
- WIDTH=8, write POLY=0xB8, SEED=0x01, CTRL=0x02 (LOAD), then 5 x CTRL=0x04 (STEP) -> STATE sequence 0xB8, 0x5C, 0x2E, 0x17, 0xB3; COUNT=5; five adv_strobe pulses.
- WIDTH=8, same setup, CTRL=0x01 (RUN) for exactly 255 cycles then CTRL=0x00 -> STATE=0x01, COUNT=255.
- SEED=0, CTRL=0x0A (LOAD+IRQ_EN) -> without feature: STATE=0, STATUS=1, irq=1 two cycles later; write STATUS=1 -> irq=0. With LFSR_AUTO_RESEED_EN: STATE=RESET_SEED, STATUS=1.
- RUN=1 and CTRL=0x03 written -> LOAD wins: STATE=SEED and COUNT=0 on that edge, no adv_strobe; advancing resumes on the next edge.
- Assert reset_n=0 mid-run with COUNT=100 -> COUNT=0, CTRL=0, STATE=RESET_SEED asynchronously; after release STATE holds across 10 idle cycles.

Source files
------------

// File: rtl/avmm_lfsr_gen.sv
// avmm_lfsr_gen: Avalon-MM slave Galois LFSR generator with its own seed.
//
// The host programs SEED and POLY, then either runs the LFSR continuously
// (CTRL.RUN) or single-steps it (CTRL.STEP). The running state is exported
// on out_port with a one-cycle adv_strobe after every advance.
//
// Register map (word address):
//   0 SEED   RW  [WIDTH-1:0]
//   1 POLY   RW  [WIDTH-1:0] Galois feedback mask
//   2 CTRL   RW  bit0 RUN, bit1 LOAD (pulse, reads 0), bit2 STEP (pulse,
//                reads 0), bit3 IRQ_EN
//   3 STATE  RO
//   4 COUNT  RO  32-bit advance counter, wraps
//   5 STATUS     bit0 ZERO, sticky, write-1-to-clear
//   6,7          read 0, writes ignored
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address/chipselect/read_n/write_n/writedata/readdata
//                         Avalon-MM slave, fixed read latency 1
//   out_port   [WIDTH-1:0] current LFSR state
//   adv_strobe             high the cycle after each advance
//   irq                    registered STATUS.ZERO & CTRL.IRQ_EN
//
// Build option: define LFSR_AUTO_RESEED_EN to replace any zero next-state
// with RESET_SEED instead of letting the LFSR lock up at 0.

module avmm_lfsr_gen #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_SEED = 32'h3F60_FF91,
  parameter logic [31:0] RESET_POLY = 32'h8020_0003
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             adv_strobe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] SEED_RST = RESET_SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] POLY_RST = RESET_POLY[WIDTH-1:0];

  localparam logic [2:0] A_SEED  = 3'd0;
  localparam logic [2:0] A_POLY  = 3'd1;
  localparam logic [2:0] A_CTRL  = 3'd2;
  localparam logic [2:0] A_STATE = 3'd3;
  localparam logic [2:0] A_COUNT = 3'd4;
  localparam logic [2:0] A_STAT  = 3'd5;

  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [31:0]      count_q, count_d;
  logic             run_q, run_d;
  logic             irq_en_q, irq_en_d;
  logic             zero_q, zero_d;
  logic             strobe_q, strobe_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr, rd, load, step, adv, upd;
  logic [WIDTH-1:0] adv_val, nxt_raw;

  always_comb begin
    wr   = chipselect & ~write_n;
    rd   = chipselect & ~read_n;
    load = wr && (address == A_CTRL) && writedata[1];
    step = wr && (address == A_CTRL) && writedata[2];

    seed_d   = seed_q;
    poly_d   = poly_q;
    run_d    = run_q;
    irq_en_d = irq_en_q;
    if (wr) begin
      case (address)
        A_SEED: seed_d = writedata[WIDTH-1:0];
        A_POLY: poly_d = writedata[WIDTH-1:0];
        A_CTRL: begin
          run_d    = writedata[0];
          irq_en_d = writedata[3];
        end
        default: ;
      endcase
    end

    // LOAD beats RUN beats STEP; a STEP written alongside RUN=1 is absorbed
    // because run_q already produces the single advance for this edge.
    adv_val = (state_q >> 1) ^ (state_q[0] ? poly_q : '0);
    adv     = ~load & (run_q | step);
    upd     = load | adv;
    nxt_raw = load ? seed_q : adv_val;

    state_d = state_q;
    if (upd) begin
`ifdef LFSR_AUTO_RESEED_EN
      state_d = (nxt_raw == '0) ? SEED_RST : nxt_raw;
`else
      state_d = nxt_raw;
`endif
    end

    count_d = count_q;
    if (load)     count_d = '0;
    else if (adv) count_d = count_q + 32'd1;

    // Set is applied after the W1C so it wins a same-cycle collision.
    zero_d = zero_q;
    if (wr && (address == A_STAT) && writedata[0]) zero_d = 1'b0;
    if (upd && (nxt_raw == '0))                    zero_d = 1'b1;

    strobe_d = adv;
    irq_d    = zero_q & irq_en_q;

    rdata_d = '0;
    if (rd) begin
      case (address)
        A_SEED:  rdata_d[WIDTH-1:0] = seed_q;
        A_POLY:  rdata_d[WIDTH-1:0] = poly_q;
        A_CTRL:  rdata_d = {28'd0, irq_en_q, 2'b00, run_q};
        A_STATE: rdata_d[WIDTH-1:0] = state_q;
        A_COUNT: rdata_d = count_q;
        A_STAT:  rdata_d = {31'd0, zero_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q   <= SEED_RST;
      poly_q   <= POLY_RST;
      state_q  <= SEED_RST;
      count_q  <= '0;
      run_q    <= 1'b0;
      irq_en_q <= 1'b0;
      zero_q   <= 1'b0;
      strobe_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      seed_q   <= seed_d;
      poly_q   <= poly_d;
      state_q  <= state_d;
      count_q  <= count_d;
      run_q    <= run_d;
      irq_en_q <= irq_en_d;
      zero_q   <= zero_d;
      strobe_q <= strobe_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata   = rdata_q;
  assign out_port   = state_q;
  assign adv_strobe = strobe_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_avmm_lfsr_gen.sv
// Directed bench for avmm_lfsr_gen: a WIDTH=32 instance for reset values
// and a WIDTH=8 instance for stepping, running, zero handling and reset.

module tb_avmm_lfsr_gen;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs32, cs8;
  logic        read_n, write_n;
  logic [31:0] writedata;
  logic [31:0] rdata32, rdata8;
  logic [31:0] out32;
  logic [7:0]  out8;
  logic        strobe32, strobe8;
  logic        irq32, irq8;

  int ncmp  = 0;
  int nfail = 0;

  avmm_lfsr_gen u32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata32), .out_port(out32), .adv_strobe(strobe32), .irq(irq32)
  );

  avmm_lfsr_gen #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata8), .out_port(out8), .adv_strobe(strobe8), .irq(irq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a negedge and consume exactly one posedge.
  task automatic wr(input bit s8, input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0;
    cs8 = s8; cs32 = ~s8;
    @(negedge clk);
    write_n = 1'b1; cs8 = 1'b0; cs32 = 1'b0;
  endtask

  task automatic rd(input bit s8, input logic [2:0] a, output logic [31:0] d);
    address = a; read_n = 1'b0;
    cs8 = s8; cs32 = ~s8;
    @(negedge clk);
    d = s8 ? rdata8 : rdata32;
    read_n = 1'b1; cs8 = 1'b0; cs32 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] d;
  logic [7:0]  exp_seq [5];
  logic [7:0]  zero_state;
  int          nstrobe;

  initial begin
    exp_seq = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
`ifdef LFSR_AUTO_RESEED_EN
    zero_state = 8'h91;
`else
    zero_state = 8'h00;
`endif
    reset_n = 1'b0; address = '0; cs32 = 1'b0; cs8 = 1'b0;
    read_n = 1'b1; write_n = 1'b1; writedata = '0;
    idle(3);
    reset_n = 1'b1;
    idle(1);

    // Reset values
    chk("rst_out32", out32, 32'h3F60_FF91);
    chk("rst_out8",  {24'd0, out8}, 32'h91);
    chk("rst_irq",   {30'd0, irq32, irq8}, 32'd0);
    chk("rst_strobe", {30'd0, strobe32, strobe8}, 32'd0);
    rd(1'b0, 3'd0, d); chk("rst_seed32",  d, 32'h3F60_FF91);
    rd(1'b0, 3'd1, d); chk("rst_poly32",  d, 32'h8020_0003);
    rd(1'b0, 3'd3, d); chk("rst_state32", d, 32'h3F60_FF91);
    rd(1'b1, 3'd1, d); chk("rst_poly8",   d, 32'h03);
    idle(1);           chk("rdata_idle0", rdata8, 32'd0);

    // Single stepping
    wr(1'b1, 3'd1, 32'hB8);
    wr(1'b1, 3'd0, 32'h01);
    wr(1'b1, 3'd2, 32'h02);
    chk("load_state",  {24'd0, out8}, 32'h01);
    chk("load_strobe", {31'd0, strobe8}, 32'd0);
    nstrobe = 0;
    for (int i = 0; i < 5; i++) begin
      wr(1'b1, 3'd2, 32'h04);
      if (strobe8) nstrobe++;
      chk($sformatf("step%0d", i), {24'd0, out8}, {24'd0, exp_seq[i]});
    end
    chk("step_strobes", nstrobe, 32'd5);
    rd(1'b1, 3'd4, d); chk("step_count", d, 32'd5);
    rd(1'b1, 3'd2, d); chk("ctrl_pulses_read0", d, 32'd0);
    wr(1'b1, 3'd3, 32'h55);
    chk("state_ro", {24'd0, out8}, 32'hB3);
    rd(1'b1, 3'd6, d); chk("addr6", d, 32'd0);
    rd(1'b1, 3'd3, d); chk("state_read", d, 32'hB3);

    // Free run for a full period of 255 advances
    wr(1'b1, 3'd2, 32'h02);
    wr(1'b1, 3'd2, 32'h01);
    idle(254);
    wr(1'b1, 3'd2, 32'h00);
    chk("run_state", {24'd0, out8}, 32'h01);
    rd(1'b1, 3'd4, d); chk("run_count", d, 32'd255);

    // LOAD beats RUN on the same edge
    wr(1'b1, 3'd2, 32'h01);
    wr(1'b1, 3'd2, 32'h03);
    chk("ldrun_state",  {24'd0, out8}, 32'h01);
    chk("ldrun_strobe", {31'd0, strobe8}, 32'd0);
    idle(1);
    chk("ldrun_resume", {24'd0, out8}, 32'hB8);
    chk("ldrun_strobe1", {31'd0, strobe8}, 32'd1);
    rd(1'b1, 3'd3, d); chk("state_pre_adv", d, 32'hB8);
    chk("state_post_adv", {24'd0, out8}, 32'h5C);
    idle(97);
    rd(1'b1, 3'd4, d); chk("ldrun_count", d, 32'd99);

    // Asynchronous reset mid-run
    reset_n = 1'b0;
    #1;
    chk("arst_state",  {24'd0, out8}, 32'h91);
    chk("arst_strobe", {31'd0, strobe8}, 32'd0);
    chk("arst_rdata",  rdata8, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    chk("arst_hold", {24'd0, out8}, 32'h91);
    rd(1'b1, 3'd4, d); chk("arst_count", d, 32'd0);
    rd(1'b1, 3'd2, d); chk("arst_ctrl",  d, 32'd0);

    // Zero state, sticky flag and interrupt
    wr(1'b1, 3'd0, 32'h00);
    wr(1'b1, 3'd2, 32'h0A);
    chk("zero_state", {24'd0, out8}, {24'd0, zero_state});
    chk("zero_irq_early", {31'd0, irq8}, 32'd0);
    idle(1);
    chk("zero_irq", {31'd0, irq8}, 32'd1);
    rd(1'b1, 3'd5, d); chk("zero_status", d, 32'd1);
    wr(1'b1, 3'd5, 32'h01);
    idle(1);
    chk("w1c_irq", {31'd0, irq8}, 32'd0);
    rd(1'b1, 3'd5, d); chk("w1c_status", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
